seq_chunk_adder: RTL
====================

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CHUNK, default 8, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request a new operation; sampled on the rising clk edge.
REQ-006 a  input  WIDTH  operand A, captured when start is accepted.
REQ-007 b  input  WIDTH  operand B, captured when start is accepted.
REQ-008 cin  input  1  carry-in, captured on accept; used only when sub=0.
REQ-009 sub  input  1  mode, captured on accept: 0 = a+b+cin, 1 = a-b (a + ~b + 1, cin ignored).
REQ-010 s  output  WIDTH  registered sum/difference.
REQ-011 cout  output  1  registered carry-out of the MSB (for sub: 1 = no borrow).
REQ-012 ovf  output  1  registered two's-complement signed overflow.
REQ-013 busy  output  1  high while the FSM is in RUN.
REQ-014 done  output  1  single-cycle result-valid strobe.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE only.
REQ-016 IDLE or DONE, start=1: latch a, b (or ~b if sub), carry register (cin, or 1 if sub), chunk index 0; go to RUN.
REQ-017 IDLE, start=0: hold state and outputs. DONE, start=0: go to IDLE.
REQ-018 RUN, each edge: s[idx*CHUNK +: CHUNK] = A_chunk + B_chunk + carry (CHUNK-bit ripple sum); carry register = chunk carry-out; idx++.
REQ-019 RUN, edge where idx = N-1: additionally set cout = final carry-out and ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1); go to DONE.
REQ-020 Latency: start accepted at edge E; done=1 for exactly the cycle following edge E+N; busy=1 for the cycles following edges E .. E+N-1.
REQ-021 start while in RUN SHALL be ignored; a, b, cin, sub changes during RUN SHALL NOT affect the result.
REQ-022 start=1 in DONE SHALL be accepted on that edge (back-to-back operation, one op per N+1 cycles).
REQ-023 s, cout and ovf SHALL hold their values from DONE until the next accepted start.
REQ-024 During RUN, s SHALL be written chunk-wise; unwritten chunks retain prior values and are not valid until done.
REQ-025 WIDTH == CHUNK (N=1) SHALL work: RUN lasts one cycle.
REQ-026 done and busy SHALL never be high in the same cycle.

Reset
REQ-027 rst=1 SHALL immediately, without a clock, force state=IDLE, idx=0, carry=0, s=0, cout=0, ovf=0, busy=0, done=0.
REQ-028 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL execute normally.
REQ-029 start coincident with rst SHALL be ignored.

Verification
REQ-030 WIDTH=32, CHUNK=8, a=4, b=6, cin=0, sub=0, start pulse -> done 4 edges after accept; s=0x0000000A, cout=0, ovf=0.
REQ-031 a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> carry ripples across all 4 chunks; s=0x00000000, cout=1, ovf=0.
REQ-032 a=0x7FFFFFFF, b=1, sub=0 -> s=0x80000000, cout=0, ovf=1. Then sub=1, a=0x80000000, b=1 -> s=0x7FFFFFFF, cout=1, ovf=1.
REQ-033 sub=1: a=5, b=7 -> s=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5 with start held in DONE (back-to-back) -> s=2, cout=1, ovf=0, no idle cycle between ops.
REQ-034 Start a=4, b=6; during RUN change a to 0xFF and pulse start -> result still s=10, exactly one done pulse.
REQ-035 Assert rst on the second RUN cycle -> all outputs 0 asynchronously, no done pulse. Rerun a=1, b=2 -> s=3. Repeat with WIDTH=CHUNK=8: a=200, b=100 -> s=44, cout=1, done 1 edge after accept.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// through a single CHUNK-bit ripple adder.
//
// Handshake: start is a single-sided request. It is taken on a rising edge
// only while the FSM is in IDLE or DONE. There is no ready output: busy=1
// means a request would be dropped. done is a one-cycle strobe, and s/cout/ovf
// are valid while it is high. They then hold until the next accepted start.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done,
    output logic [1:0]       o_dbg_state
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [IDXW-1:0]  r_idx;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_sum;
    logic             w_last;
    logic             w_accept;
    logic             w_ovf;

    assign w_a_chunk = r_a[int'(r_idx) * CHUNK +: CHUNK];
    assign w_b_chunk = r_b[int'(r_idx) * CHUNK +: CHUNK];
    assign w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    assign w_last    = (r_idx == IDXW'(N - 1));
    // The carry into the MSB is recovered as a ^ b ^ sum at that bit.
    assign w_ovf     = w_sum[CHUNK] ^ (w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1]);
    assign w_accept  = start && (r_state != RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            // Subtraction is performed as a + ~b + 1, so cin is not used when sub=1.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_s[int'(r_idx) * CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
            r_carry <= w_sum[CHUNK];
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_sum[CHUNK];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign s           = r_s;
    assign cout        = r_cout;
    assign ovf         = r_ovf;
    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign o_dbg_state = r_state;

endmodule
